// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner_sync
// Description : Plain two-flop synchronizer for a bus of independent
//               asynchronous bits. Deliberately not reset: its contents are
//               don't-care for two cycles after power-up or reset.
// Ports       : clk - system clock
//               i_d - asynchronous input bus
//               o_q - synchronized output bus (second flop)
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge clk) begin
    r_q1 <= i_d;
    r_q2 <= r_q1;
  end

  assign o_q = r_q2;

endmodule

// ============================================================================
// Module      : input_conditioner
// Description : Conditions raw arcade player inputs. Each channel is
//               synchronized, optionally inverted to active-high, and then
//               debounced by a two-state machine counting prescaled ticks.
//               Emits debounced levels plus one-cycle rise/fall strobes.
// Ports       : clk   - system clock
//               reset - synchronous, active-high reset
//               in    - raw asynchronous inputs (WIDTH)
//               level - debounced active-high level per channel
//               rise  - one-cycle strobe when level goes 0->1
//               fall  - one-cycle strobe when level goes 1->0
//               tick  - prescaler tick, one cycle every PRESCALE cycles
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner #(
  parameter int WIDTH          = 4,
  parameter int PRESCALE       = 1000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             tick
);

  // A one-cycle prescaler still needs a 1-bit counter to be legal.
  localparam int            c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int            c_CW       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [c_PW-1:0] c_PMAX   = c_PW'(PRESCALE - 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_TICKS - 1);
  localparam logic          c_INV      = (ACTIVE_LOW != 0);

  localparam logic          c_STABLE   = 1'b0;
  localparam logic          c_PENDING  = 1'b1;

  logic [WIDTH-1:0] w_q2;
  logic [WIDTH-1:0] w_sync;

  input_conditioner_sync #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk (clk),
    .i_d (in),
    .o_q (w_q2)
  );

  assign w_sync = w_q2 ^ {WIDTH{c_INV}};

  // --------------------------------------------------------------------------
  // Prescaler. The tick is registered from the next count value so that it
  // is high exactly in the cycle where the count sits at PRESCALE-1, while
  // still reading zero in the cycle right after a reset edge.
  // --------------------------------------------------------------------------
  logic [c_PW-1:0] r_pcnt;
  logic [c_PW-1:0] w_pcnt_nxt;
  logic            r_tick;

  assign w_pcnt_nxt = (r_pcnt == c_PMAX) ? '0 : r_pcnt + c_PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pcnt <= w_pcnt_nxt;
      r_tick <= (w_pcnt_nxt == c_PMAX);
    end
  end

  assign tick = r_tick;

  // --------------------------------------------------------------------------
  // Per-channel debounce machines.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic            r_state;
    logic            w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            r_lvl;
    logic            r_rise;
    logic            r_fall;
    logic            w_diff;
    logic            w_accept;
    logic            w_lvl_nxt;
    logic            w_rise_nxt;
    logic            w_fall_nxt;

    assign w_diff = w_sync[i] ^ r_lvl;

    // State register
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= c_STABLE;
        r_cnt   <= '0;
        r_lvl   <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_lvl   <= w_lvl_nxt;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    // Next-state logic. A glitch back to the current level wins over a
    // coincident tick; the entry cycle into PENDING never counts a tick.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      case (r_state)
        c_STABLE: begin
          w_cnt_nxt = '0;
          if (w_diff) begin
            w_state_nxt = c_PENDING;
          end
        end
        c_PENDING: begin
          if (!w_diff) begin
            w_state_nxt = c_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_tick) begin
            if (r_cnt == c_CNT_LAST) begin
              w_accept    = 1'b1;
              w_state_nxt = c_STABLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + c_CW'(1);
            end
          end
        end
      endcase
    end

    // Output logic: the accepted change flips the level and fires the
    // strobe matching its direction.
    always_comb begin
      w_lvl_nxt  = r_lvl ^ w_accept;
      w_rise_nxt = w_accept & ~r_lvl;
      w_fall_nxt = w_accept & r_lvl;
    end

    assign level[i] = r_lvl;
    assign rise[i]  = r_rise;
    assign fall[i]  = r_fall;
  end

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Bench for input_conditioner. Two instances: A (PRESCALE=4,
//               DEBOUNCE_TICKS=3) and B (PRESCALE=1, DEBOUNCE_TICKS=1), both
//               active-low. A behavioural model predicts levels, ticks and
//               strobe events; events go into a per-instance FIFO that a
//               monitor drains whenever a DUT presents a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_a, in_b;
  logic [3:0] level_a, rise_a, fall_a;
  logic [3:0] level_b, rise_b, fall_b;
  logic       tick_a, tick_b;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH(4), .PRESCALE(4), .DEBOUNCE_TICKS(3), .ACTIVE_LOW(1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .in(in_a),
    .level(level_a), .rise(rise_a), .fall(fall_a), .tick(tick_a)
  );

  input_conditioner #(
    .WIDTH(4), .PRESCALE(1), .DEBOUNCE_TICKS(1), .ACTIVE_LOW(1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .in(in_b),
    .level(level_b), .rise(rise_b), .fall(fall_b), .tick(tick_b)
  );

  function automatic int cfg_pre(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int cfg_dt(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  // ---------------- reference model (written only at posedge) ---------------
  int         mcyc = 0;
  int         n_since [2];
  bit         m_tick  [2];
  bit   [3:0] m_lvl   [2];
  bit   [3:0] m_s1    [2];
  bit   [3:0] m_s2    [2];
  bit   [3:0] m_pend  [2];
  int         m_ticks [2][4];
  bit   [3:0] m_act, m_er, m_ef;
  bit   [3:0] m_raw   [2];
  int         ev_cyc  [2][256];
  bit   [3:0] ev_r    [2][256];
  bit   [3:0] ev_f    [2][256];
  int         wr      [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      wr[d] = 0; n_since[d] = 0; m_tick[d] = 0; m_lvl[d] = 0;
      m_s1[d] = 0; m_s2[d] = 0; m_pend[d] = 0;
    end
  end

  always @(posedge clk) begin
    mcyc++;
    m_raw[0] = in_a;
    m_raw[1] = in_b;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        n_since[d] = 0;
        m_tick[d]  = 0;
        m_lvl[d]   = 0;
        m_pend[d]  = 0;
      end else begin
        // active-high view of the input as it was two edges ago
        m_act = ~m_s2[d];
        m_er  = 0;
        m_ef  = 0;
        for (int ch = 0; ch < 4; ch++) begin
          if (m_act[ch] != m_lvl[d][ch]) begin
            if (!m_pend[d][ch]) begin
              m_pend[d][ch] = 1;
              m_ticks[d][ch] = 0;
            end else if (m_tick[d]) begin
              m_ticks[d][ch]++;
              if (m_ticks[d][ch] == cfg_dt(d)) begin
                if (m_act[ch]) m_er[ch] = 1;
                else           m_ef[ch] = 1;
                m_pend[d][ch] = 0;
              end
            end
          end else begin
            m_pend[d][ch] = 0;
          end
        end
        m_lvl[d] = m_lvl[d] ^ (m_er | m_ef);
        if ((m_er | m_ef) != 0) begin
          ev_cyc[d][wr[d] & 255] = mcyc;
          ev_r[d][wr[d] & 255]   = m_er;
          ev_f[d][wr[d] & 255]   = m_ef;
          wr[d]++;
        end
        n_since[d]++;
        m_tick[d] = ((n_since[d] % cfg_pre(d)) == cfg_pre(d) - 1);
      end
      m_s2[d] = m_s1[d];
      m_s1[d] = m_raw[d];
    end
  end

  // ---------------- stimulus ------------------------------------------------
  bit done = 0;
  int mark_a_cyc = 0, mark_a_id = 0;
  int mark_b_cyc = 0, mark_b_id = 0;

  initial begin
    reset = 1'b1;
    in_a  = 4'hF;
    in_b  = 4'hF;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    // single channel press
    in_a[0] = 1'b0; mark_a_cyc = mcyc; mark_a_id++;
    repeat (25) @(negedge clk);

    // short glitch that must be rejected
    in_a[1] = 1'b0;
    repeat (6) @(negedge clk);
    in_a[1] = 1'b1;
    repeat (20) @(negedge clk);

    // two channels together
    in_a[3:2] = 2'b00;
    repeat (25) @(negedge clk);
    in_a[3:2] = 2'b11;
    repeat (25) @(negedge clk);

    // release ch0, then press again and reset mid-debounce
    in_a[0] = 1'b1;
    repeat (25) @(negedge clk);
    in_a[0] = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mark_a_cyc = mcyc; mark_a_id++;
    repeat (25) @(negedge clk);
    in_a[0] = 1'b1;
    repeat (25) @(negedge clk);

    // fast instance: press, then toggle every 2 cycles
    in_b[0] = 1'b0; mark_b_cyc = mcyc; mark_b_id++;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      in_b[0] = ~in_b[0];
      repeat (2) @(negedge clk);
    end
    in_b[0] = 1'b1;
    repeat (10) @(negedge clk);

    // randomized holds, including an occasional reset pulse
    for (int k = 0; k < 60; k++) begin
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      if (k == 30) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      repeat (int'($urandom_range(1, 20))) @(negedge clk);
    end
    in_a = 4'hF;
    in_b = 4'hF;
    repeat (30) @(negedge clk);
    done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  // ---------------- monitor / scoreboard ------------------------------------
  int         checks = 0;
  int         errors = 0;
  int         rd [2] = '{0, 0};
  int         seen_a = 0, seen_b = 0;
  int         lat;
  logic [3:0] d_lvl, d_r, d_f;
  logic       d_tick;

  always @(negedge clk) begin
    if (mcyc >= 1) begin
      for (int d = 0; d < 2; d++) begin
        d_lvl  = (d == 0) ? level_a : level_b;
        d_r    = (d == 0) ? rise_a  : rise_b;
        d_f    = (d == 0) ? fall_a  : fall_b;
        d_tick = (d == 0) ? tick_a  : tick_b;

        checks++;
        if (d_lvl !== m_lvl[d]) begin
          errors++;
          $display("FAIL level dut%0d cyc=%0d: got %h expected %h", d, mcyc, d_lvl, m_lvl[d]);
        end
        checks++;
        if (d_tick !== m_tick[d]) begin
          errors++;
          $display("FAIL tick dut%0d cyc=%0d: got %b expected %b", d, mcyc, d_tick, m_tick[d]);
        end

        while (rd[d] != wr[d] && ev_cyc[d][rd[d] & 255] < mcyc) begin
          checks++;
          errors++;
          $display("FAIL missed_strobe dut%0d cyc=%0d: got none expected rise=%h fall=%h at cyc %0d",
                   d, mcyc, ev_r[d][rd[d] & 255], ev_f[d][rd[d] & 255], ev_cyc[d][rd[d] & 255]);
          rd[d]++;
        end

        if ((d_r | d_f) != 0) begin
          checks++;
          if (rd[d] == wr[d]) begin
            errors++;
            $display("FAIL unexpected_strobe dut%0d cyc=%0d: got rise=%h fall=%h expected none",
                     d, mcyc, d_r, d_f);
          end else begin
            if (ev_cyc[d][rd[d] & 255] != mcyc || d_r !== ev_r[d][rd[d] & 255] ||
                d_f !== ev_f[d][rd[d] & 255]) begin
              errors++;
              $display("FAIL strobe dut%0d cyc=%0d: got rise=%h fall=%h expected rise=%h fall=%h at cyc %0d",
                       d, mcyc, d_r, d_f, ev_r[d][rd[d] & 255], ev_f[d][rd[d] & 255],
                       ev_cyc[d][rd[d] & 255]);
            end
            rd[d]++;
          end
        end
      end

      if (rise_a[0] && mark_a_id != seen_a) begin
        checks++;
        lat = mcyc - mark_a_cyc;
        if (lat < 12 || lat > 15) begin
          errors++;
          $display("FAIL latency_a: got %0d cycles expected 12..15", lat);
        end
        seen_a = mark_a_id;
      end
      if (rise_b[0] && mark_b_id != seen_b) begin
        checks++;
        lat = mcyc - mark_b_cyc;
        if (lat != 4) begin
          errors++;
          $display("FAIL latency_b: got %0d cycles expected 4", lat);
        end
        seen_b = mark_b_id;
      end

      if (done) begin
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (rd[d] != wr[d]) begin
            errors++;
            $display("FAIL drain dut%0d: got %0d strobes pending expected 0", d, wr[d] - rd[d]);
          end
        end
        checks++;
        if (seen_a != 2 || seen_b != 1) begin
          errors++;
          $display("FAIL latency_seen: got a=%0d b=%0d expected a=2 b=1", seen_a, seen_b);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

endmodule
`default_nettype wire
